// File: rtl/masked_cam_pkg.sv
// Shared definitions for the masked tag CAM.
// The default entry format is the {cmd_id, proc_id} tag tracked between the
// command dispatcher and the processor return path. cmd_id sits in the upper
// bits, so a care mask of 0xFC selects cmd_id and 0x03 selects proc_id.
package masked_cam_pkg;

    localparam int PROC_ID_WIDTH = 2;
    localparam int CMD_ID_WIDTH  = 6;

    typedef logic [CMD_ID_WIDTH-1:0]  cmd_id_t;
    typedef logic [PROC_ID_WIDTH-1:0] proc_id_t;

    // Natural CAM entry width for one outstanding tag.
    localparam int TAG_WIDTH = $bits(cmd_id_t) + $bits(proc_id_t);

    // Write-side operation codes; 6 and 7 are illegal and report op_err.
    typedef enum logic [2:0] {
        CAM_OP_NOP          = 3'd0,
        CAM_OP_INSERT       = 3'd1,
        CAM_OP_WRITE        = 3'd2,
        CAM_OP_DELETE       = 3'd3,
        CAM_OP_DELETE_MATCH = 3'd4,
        CAM_OP_CLEAR        = 3'd5
    } cam_op_t;

endpackage

// File: rtl/masked_cam_prio_enc.sv
// Lowest-index priority encoder.
// Ports:
//   req    - request vector, bit i set means entry i is a candidate
//   onehot - one-hot of the lowest set request bit (all zero if none)
//   idx    - index of the lowest set request bit (zero if none)
//   any    - at least one request bit is set
module cam_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = req & (~req + N'(1));
    assign any    = |req;

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        idx = '0;
        // Walk downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/masked_cam.sv
// Register-based masked CAM for outstanding {cmd_id, proc_id} tags.
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-low reset
//   op_valid/op_code    - write-side operation (cam_op_t) accepted every cycle
//   op_addr/op_data/op_mask - target slot, entry data or key, care mask
//   op_done/op_err/op_rsp_addr - registered outcome, one cycle after the op
//   search_valid/search_key/search_mask - masked search request
//   result_valid, match_many/single/addr, match, match_count - registered result
//   occupancy/full/empty - registered valid-entry count and flags
module masked_cam
    import masked_cam_pkg::*;
#(
    parameter  int DATA_WIDTH = TAG_WIDTH,
    parameter  int ADDR_WIDTH = 3,
    parameter  int CNT_WIDTH  = ADDR_WIDTH + 1,
    localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [2:0]            op_code,
    input  logic [ADDR_WIDTH-1:0] op_addr,
    input  logic [DATA_WIDTH-1:0] op_data,
    input  logic [DATA_WIDTH-1:0] op_mask,
    output logic                  op_done,
    output logic                  op_err,
    output logic [ADDR_WIDTH-1:0] op_rsp_addr,
    input  logic                  search_valid,
    input  logic [DATA_WIDTH-1:0] search_key,
    input  logic [DATA_WIDTH-1:0] search_mask,
    output logic                  result_valid,
    output logic [DEPTH-1:0]      match_many,
    output logic [DEPTH-1:0]      match_single,
    output logic [ADDR_WIDTH-1:0] match_addr,
    output logic                  match,
    output logic [CNT_WIDTH-1:0]  match_count,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic                  full,
    output logic                  empty
);

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) n = n + CNT_WIDTH'(v[i]);
        return n;
    endfunction

    logic [DATA_WIDTH-1:0] entry_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [DEPTH-1:0]      wr_sel;
    logic [DEPTH-1:0]      search_hits;
    logic [DEPTH-1:0]      op_hits;
    logic [CNT_WIDTH-1:0]  occ_d;

    cam_op_t op;
    assign op = cam_op_t'(op_code);

    // Both hit vectors look at the pre-op contents.
    always_comb begin
        search_hits = '0;
        op_hits     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            search_hits[i] = valid_q[i] & ~|((entry_q[i] ^ search_key) & search_mask);
            op_hits[i]     = valid_q[i] & ~|((entry_q[i] ^ op_data) & op_mask);
        end
    end

    logic [DEPTH-1:0]      srch_onehot;
    logic [ADDR_WIDTH-1:0] srch_idx;
    logic                  srch_any;

    cam_prio_enc #(.N(DEPTH), .IDX_W(ADDR_WIDTH)) u_search_enc (
        .req    (search_hits),
        .onehot (srch_onehot),
        .idx    (srch_idx),
        .any    (srch_any)
    );

    // The op-side encoder is time-shared: INSERT looks for the lowest free
    // slot, DELETE_MATCH for the lowest hit. Only one op exists per cycle.
    logic [DEPTH-1:0]      op_enc_req;
    logic [DEPTH-1:0]      op_onehot;
    logic [ADDR_WIDTH-1:0] op_idx;
    logic                  op_any;

    assign op_enc_req = (op == CAM_OP_INSERT) ? ~valid_q : op_hits;

    cam_prio_enc #(.N(DEPTH), .IDX_W(ADDR_WIDTH)) u_op_enc (
        .req    (op_enc_req),
        .onehot (op_onehot),
        .idx    (op_idx),
        .any    (op_any)
    );

    // Next-state decode for the valid bits and the op response.
    logic                  done_d;
    logic                  err_d;
    logic [ADDR_WIDTH-1:0] rsp_d;

    always_comb begin
        valid_d = valid_q;
        wr_sel  = '0;
        done_d  = op_valid && (op != CAM_OP_NOP);
        err_d   = 1'b0;
        rsp_d   = op_addr;
        if (op_valid) begin
            case (op)
                CAM_OP_NOP: ;
                CAM_OP_INSERT: begin
                    if (op_any) begin
                        wr_sel = op_onehot;
                        rsp_d  = op_idx;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CAM_OP_WRITE:        wr_sel = DEPTH'(1) << op_addr;
                CAM_OP_DELETE:       valid_d[op_addr] = 1'b0;
                CAM_OP_DELETE_MATCH: begin
                    valid_d = valid_q & ~op_hits;
                    rsp_d   = op_any ? op_idx : '0;
                end
                CAM_OP_CLEAR:        valid_d = '0;
                default:             err_d = 1'b1;
            endcase
        end
        valid_d = valid_d | wr_sel;
        occ_d   = popcount(valid_d);
    end

    // NOTE: entry data is deliberately not reset; an entry is meaningless
    // while its valid bit is clear, and leaving the array reset-free keeps it
    // a plain register file.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) entry_q[i] <= op_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q      <= '0;
            occupancy    <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            op_done      <= 1'b0;
            op_err       <= 1'b0;
            op_rsp_addr  <= '0;
            result_valid <= 1'b0;
            match_many   <= '0;
            match_single <= '0;
            match_addr   <= '0;
            match        <= 1'b0;
            match_count  <= '0;
        end else begin
            valid_q      <= valid_d;
            occupancy    <= occ_d;
            full         <= (occ_d == CNT_WIDTH'(DEPTH));
            empty        <= (occ_d == '0);
            op_done      <= done_d;
            result_valid <= search_valid;
            if (op_valid) begin
                op_err      <= err_d;
                op_rsp_addr <= rsp_d;
            end
            // Match outputs hold their last value when no search is issued.
            if (search_valid) begin
                match_many   <= search_hits;
                match_single <= srch_onehot;
                match_addr   <= srch_idx;
                match        <= srch_any;
                match_count  <= popcount(search_hits);
            end
        end
    end

endmodule
